// File: rtl/uart_frame_parser.sv
// Turns the UART receiver byte stream into checksum-verified command frames.
// Good frames are held on a valid/ready interface; bad frames produce a one-cycle error pulse and a code.
module uart_frame_parser #(
  parameter int unsigned MAX_PAYLOAD  = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 2200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               RXout,
  input  logic                     RXdone,
  input  logic                     parityError,
  input  logic                     cmdReady,
  output logic                     cmdValid,
  output logic [7:0]               cmdOpcode,
  output logic [7:0]               cmdAddr,
  output logic [7:0]               cmdLen,
  output logic [MAX_PAYLOAD*8-1:0] payloadOut,
  output logic                     frameError,
  output logic [2:0]               errCode
);

  localparam int unsigned PW      = MAX_PAYLOAD * 8;
  localparam int unsigned TW      = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] LEN_MAX  = 8'(MAX_PAYLOAD);

  localparam logic [2:0] ERR_PARITY   = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_LENGTH   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

  typedef enum logic [2:0] {
    S_SYNC,
    S_OPCODE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHECK,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            valid_d;
  logic [7:0]      opcode_d, addr_d, len_d;
  logic [PW-1:0]   payload_d;
  logic            err_d;
  logic [2:0]      code_d;
  logic            in_frame;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and error logic
  always_comb begin
    state_d   = state_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    tmr_d     = '0;
    opcode_d  = cmdOpcode;
    addr_d    = cmdAddr;
    len_d     = cmdLen;
    payload_d = payloadOut;
    err_d     = 1'b0;
    code_d    = errCode;
    in_frame  = (state_q inside {S_OPCODE, S_ADDR, S_LEN, S_PAYLOAD, S_CHECK});

    // Inter-byte timeout; a byte arriving in the expiry cycle wins
    if (in_frame && !RXdone) begin
      if (tmr_q == TMAX) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = S_SYNC;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end

    if (RXdone) begin
      case (state_q)
        S_SYNC: begin
          if (!parityError && RXout == SYNC_BYTE) begin
            payload_d = '0;
            csum_d    = '0;
            idx_d     = '0;
            state_d   = S_OPCODE;
          end
        end
        S_HOLD: begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        default: begin
          if (parityError) begin
            err_d   = 1'b1;
            code_d  = ERR_PARITY;
            state_d = S_SYNC;
          end else begin
            case (state_q)
              S_OPCODE: begin
                opcode_d = RXout;
                csum_d   = csum_q ^ RXout;
                state_d  = S_ADDR;
              end
              S_ADDR: begin
                addr_d  = RXout;
                csum_d  = csum_q ^ RXout;
                state_d = S_LEN;
              end
              S_LEN: begin
                len_d  = RXout;
                csum_d = csum_q ^ RXout;
                idx_d  = '0;
                if (RXout > LEN_MAX) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LENGTH;
                  state_d = S_SYNC;
                end else if (RXout == 8'd0) begin
                  state_d = S_CHECK;
                end else begin
                  state_d = S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
                  if (idx_q == 8'(i)) payload_d[i*8 +: 8] = RXout;
                end
                csum_d = csum_q ^ RXout;
                if (idx_q == cmdLen - 8'd1) begin
                  state_d = S_CHECK;
                end else begin
                  idx_d = idx_q + 8'd1;
                end
              end
              S_CHECK: begin
                if (RXout == csum_q) begin
                  state_d = S_HOLD;
                end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CHECKSUM;
                  state_d = S_SYNC;
                end
              end
              default: state_d = S_SYNC;
            endcase
          end
        end
      endcase
    end

    // Handshake completes even when an overrun byte lands in the same cycle
    if (state_q == S_HOLD && cmdReady) begin
      state_d = S_SYNC;
    end

    valid_d = (state_d == S_HOLD);
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q     <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      cmdValid   <= 1'b0;
      cmdOpcode  <= '0;
      cmdAddr    <= '0;
      cmdLen     <= '0;
      payloadOut <= '0;
      frameError <= 1'b0;
      errCode    <= '0;
    end else begin
      csum_q     <= csum_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      cmdValid   <= valid_d;
      cmdOpcode  <= opcode_d;
      cmdAddr    <= addr_d;
      cmdLen     <= len_d;
      payloadOut <= payload_d;
      frameError <= err_d;
      errCode    <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
// Bytes are driven and outputs sampled on the falling clock edge.
module tb_uart_frame_parser;

  localparam int unsigned MAXP = 16;
  localparam int unsigned TO   = 2200;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        RXout;
  logic              RXdone;
  logic              parityError;
  logic              cmdReady;
  logic              cmdValid;
  logic [7:0]        cmdOpcode, cmdAddr, cmdLen;
  logic [MAXP*8-1:0] payloadOut;
  logic              frameError;
  logic [2:0]        errCode;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int snap;

  uart_frame_parser #(
    .MAX_PAYLOAD(MAXP),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RXout(RXout),
    .RXdone(RXdone),
    .parityError(parityError),
    .cmdReady(cmdReady),
    .cmdValid(cmdValid),
    .cmdOpcode(cmdOpcode),
    .cmdAddr(cmdAddr),
    .cmdLen(cmdLen),
    .payloadOut(payloadOut),
    .frameError(frameError),
    .errCode(errCode)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frameError) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    @(negedge clk);
    RXout = b; RXdone = 1'b1; parityError = par;
    @(negedge clk);
    RXdone = 1'b0; parityError = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; RXout = '0; RXdone = 1'b0; parityError = 1'b0; cmdReady = 1'b1;
    idle(3);
    check("rst_valid", 128'(cmdValid), 128'd0);
    check("rst_ferr", 128'(frameError), 128'd0);
    check("rst_code", 128'(errCode), 128'd0);
    check("rst_opcode", 128'(cmdOpcode), 128'd0);
    check("rst_payload", payloadOut, 128'd0);
    rst = 1'b1;
    idle(2);

    // Good frame with consumer ready
    snap = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h02, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'h60, 0);
    check("good_valid", 128'(cmdValid), 128'd1);
    check("good_opcode", 128'(cmdOpcode), 128'h01);
    check("good_addr", 128'(cmdAddr), 128'h10);
    check("good_len", 128'(cmdLen), 128'd2);
    check("good_payload", payloadOut, 128'hADDE);
    idle(1);
    check("good_valid_drop", 128'(cmdValid), 128'd0);
    idle(3);
    check("good_no_err", 128'(err_cnt - snap), 128'd0);

    // Backpressure, overrun byte while holding
    cmdReady = 1'b0;
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h02, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'h60, 0);
    check("bp_valid", 128'(cmdValid), 128'd1);
    send_byte(8'h33, 0);
    check("ovr_ferr", 128'(frameError), 128'd1);
    check("ovr_code", 128'(errCode), 128'd5);
    check("ovr_valid", 128'(cmdValid), 128'd1);
    check("ovr_payload", payloadOut, 128'hADDE);
    check("ovr_opcode", 128'(cmdOpcode), 128'h01);
    idle(100);
    check("bp_hold_valid", 128'(cmdValid), 128'd1);
    check("bp_ferr_pulse", 128'(frameError), 128'd0);
    cmdReady = 1'b1;
    idle(1);
    check("bp_valid_drop", 128'(cmdValid), 128'd0);
    idle(2);

    // Bad checksum
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    check("csum_ferr", 128'(frameError), 128'd1);
    check("csum_code", 128'(errCode), 128'd2);
    check("csum_valid", 128'(cmdValid), 128'd0);
    idle(2);

    // Length above maximum
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h11, 0);
    check("len_ferr", 128'(frameError), 128'd1);
    check("len_code", 128'(errCode), 128'd3);
    idle(3);

    // Sync byte with parity error is ignored
    snap = err_cnt;
    send_byte(8'hA5, 1);
    idle(3);
    check("par_sync_ignored", 128'(err_cnt - snap), 128'd0);
    send_byte(8'hA5, 0); send_byte(8'h01, 1);
    check("par_ferr", 128'(frameError), 128'd1);
    check("par_code", 128'(errCode), 128'd1);
    send_byte(8'hA5, 0); send_byte(8'h07, 0); send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0); send_byte(8'h73, 0);
    check("par_recover_valid", 128'(cmdValid), 128'd1);
    check("par_recover_payload", payloadOut, 128'h55);
    check("par_recover_opcode", 128'(cmdOpcode), 128'h07);
    idle(3);

    // Timeout: error visible TIMEOUT_CLKS edges after the RXdone edge
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    idle(TO - 1);
    check("to_early", 128'(frameError), 128'd0);
    idle(1);
    check("to_ferr", 128'(frameError), 128'd1);
    check("to_code", 128'(errCode), 128'd4);
    idle(3);

    // Byte landing in the expiry cycle is processed, no timeout
    snap = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    idle(TO - 2);
    send_byte(8'h10, 0);
    check("to_edge_ferr", 128'(frameError), 128'd0);
    send_byte(8'h00, 0); send_byte(8'h11, 0);
    check("to_edge_valid", 128'(cmdValid), 128'd1);
    check("to_edge_addr", 128'(cmdAddr), 128'h10);
    idle(3);
    check("to_edge_no_err", 128'(err_cnt - snap), 128'd0);

    // Zero-length frame
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    check("len0_valid", 128'(cmdValid), 128'd1);
    check("len0_len", 128'(cmdLen), 128'd0);
    check("len0_opcode", 128'(cmdOpcode), 128'h03);
    check("len0_payload", payloadOut, 128'd0);
    idle(3);

    // Reset in the middle of the payload
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h04, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    check("mid_payload_pre", payloadOut, 128'hBBAA);
    rst = 1'b0;
    #1;
    check("mid_rst_opcode", 128'(cmdOpcode), 128'd0);
    check("mid_rst_len", 128'(cmdLen), 128'd0);
    check("mid_rst_payload", payloadOut, 128'd0);
    check("mid_rst_code", 128'(errCode), 128'd0);
    idle(2);
    rst = 1'b1;
    idle(2);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h30, 0); send_byte(8'h01, 0);
    send_byte(8'h77, 0); send_byte(8'h44, 0);
    check("post_rst_valid", 128'(cmdValid), 128'd1);
    check("post_rst_opcode", 128'(cmdOpcode), 128'h02);
    check("post_rst_payload", payloadOut, 128'h77);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Sits directly downstream of the UART receiver in the Tiny FSM Control path and turns its byte stream into checked command frames for the vector unit. It hunts for a sync byte, collects opcode, address, length and payload, and verifies an XOR checksum. A good frame is presented on a valid/ready command interface with the payload as a flat byte vector. Bad frames are dropped and reported with a one-cycle error pulse and code.

## Interface
- MAX_PAYLOAD, 16: payload buffer depth in bytes; legal LEN is 0..MAX_PAYLOAD.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 2200: inter-byte timeout in clk cycles (4 byte-times at 50 clk/bit, 11 bits/byte).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-low.
- RXout  in  8  received byte from the UART receiver.
- RXdone  in  1  one-cycle pulse; RXout and parityError are valid in the same cycle.
- parityError  in  1  parity flag for the current byte.
- cmdReady  in  1  consumer accepts the command.
- cmdValid  out  1  a checked frame is held on the outputs.
- cmdOpcode  out  8  frame opcode.
- cmdAddr  out  8  frame address.
- cmdLen  out  8  payload length.
- payloadOut  out  MAX_PAYLOAD*8  payload bytes; byte i is at bits [8i+7:8i].
- frameError  out  1  one-cycle error pulse.
- errCode  out  3  cause of the error: 1 parity, 2 checksum, 3 length, 4 timeout, 5 overrun. Holds its last value until the next error.

## Operation
- States and transitions:
  - SYNC: waits for the sync byte. On an RXdone byte equal to SYNC_BYTE with no parity error, clears payloadOut to 0, clears the running checksum, then goes to OPCODE. All other bytes are ignored silently, including bytes with a parity error.
  - OPCODE: the byte is stored in cmdOpcode; go to ADDR.
  - ADDR: the byte is stored in cmdAddr; go to LEN.
  - LEN: the byte is stored in cmdLen.
    - If LEN > MAX_PAYLOAD: error 3, return to SYNC.
    - If LEN == 0: go to CHECK.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: byte k is written to payload slot k. After slot LEN-1 is written, go to CHECK.
  - CHECK: compares the received byte with the running checksum.
    - Equal: go to HOLD.
    - Not equal: error 2, return to SYNC.
  - HOLD: cmdValid=1. When cmdValid&&cmdReady, return to SYNC.
- Running checksum is the XOR of the opcode, address, len and payload bytes; the sync byte is excluded.
- Parity: a byte with parityError=1 in OPCODE..CHECK causes error 1 and a return to SYNC.
- Timeout: a counter runs in OPCODE..CHECK and is cleared on every RXdone. When it reaches TIMEOUT_CLKS-1: error 4, return to SYNC. The counter is idle in SYNC and HOLD.
- Overrun: an RXdone in HOLD causes error 5. The byte is dropped, the parser stays in HOLD, and the held outputs are unchanged.
- Simultaneous events:
  - RXdone and timeout expiry in the same cycle: the byte is processed, and no timeout is raised.
  - In HOLD, RXdone together with cmdReady: the handshake completes and the byte is still reported as overrun.
- cmdOpcode, cmdAddr, cmdLen and payloadOut are stable for the whole time cmdValid=1.
- Payload slots at index LEN and above read 0.

## Timing
- Reset (rst=0, asynchronous):
  - state goes to SYNC.
  - cmdValid, frameError, errCode, cmdOpcode, cmdAddr, cmdLen, payloadOut, the checksum and the timeout counter all go to 0.
  - A reset mid-frame or in HOLD discards everything.
- All state changes occur on the RXdone cycle. Each byte is consumed in exactly one cycle.
- cmdValid rises on the clk edge after the checksum byte's RXdone.
- cmdValid falls on the edge after the cycle in which cmdValid&&cmdReady is high. SYNC is active on that same edge.
- cmdReady may be high before cmdValid. A command is never accepted without cmdValid=1.
- frameError is high for exactly one cycle, the cycle after the offending RXdone or timeout expiry. errCode updates on that same edge.

## Test plan
- Good frame:
  - Stimulus: A5 01 10 02 DE AD 60, with cmdReady=1.
  - Response: cmdValid=1 for one cycle, opcode 0x01, addr 0x10, len 2, payloadOut[15:0]=0xADDE, all other slots 0, no frameError.
- Backpressure and overrun:
  - Stimulus: the same frame with cmdReady=0, then one extra byte 0x33, then cmdReady=1 after 100 cycles.
  - Response: error 5 pulse on the extra byte, outputs unchanged, cmdValid drops one cycle after the handshake.
- Bad checksum and length:
  - Stimulus: A5 01 10 00 12.
  - Response: error 2 pulse, cmdValid stays 0.
  - Stimulus: A5 01 10 11 (LEN 17 with MAX_PAYLOAD 16).
  - Response: error 3 pulse right after the LEN byte.
- Parity:
  - Stimulus: A5 with parityError=1.
  - Response: ignored, no error.
  - Stimulus: A5, then opcode 01 with parityError=1.
  - Response: error 1, back to SYNC. A following good frame is accepted.
- Timeout and recovery:
  - Stimulus: A5 01, then silence for 2200 cycles.
  - Response: error 4 exactly TIMEOUT_CLKS cycles after the last RXdone.
  - Stimulus: a byte landing in the expiry cycle.
  - Response: no error.
  - Stimulus: a following A5 03 00 00 03.
  - Response: cmdValid with len 0.
- Reset mid-frame:
  - Stimulus: drive rst low during PAYLOAD.
  - Response: all outputs go to 0 immediately. A new frame after release is parsed correctly.
